l2_rd_mem_arb: RTL and testbench

// - Parametrised N-channel banked read-memory model with arbitration, for L2 downlink benches (rx_mac, dtc and future readers).
// - Shared word array; per-channel read port with ready handshake, fixed LAT-cycle pipeline, tag return and per-channel data inversion.
// - Bank conflicts are stalled (ch_rdy low), never dropped.
// - Includes a backdoor write port for preload and a saturating conflict counter.

---
 rtl/l2_rd_mem_arb.sv | 142 ++++++++++++++
 tb/tb_l2_rd_mem_arb.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_rd_mem_arb.sv
// Banked N-channel read-memory model: per-bank arbitration, fixed-latency return
// pipeline per channel with tag and data-inversion, backdoor write, conflict counter.
module l2_rd_mem_arb #(
    parameter int NCH       = 2,
    parameter int AW        = 14,
    parameter int DW        = 128,
    parameter int TW        = 12,
    parameter int BANK_BITS = 4,
    parameter int LAT       = 5,
    parameter int ARB_MODE  = 0
) (
    input  logic                clk983m,
    input  logic                clkgen_rst,
    input  logic [NCH-1:0]      ch_re,
    input  logic [NCH*AW-1:0]   ch_raddr,
    input  logic [NCH*TW-1:0]   ch_tag,
    output logic [NCH-1:0]      ch_rdy,
    output logic [NCH-1:0]      ch_rvld,
    output logic [NCH*DW-1:0]   ch_rdata,
    output logic [NCH*TW-1:0]   ch_rtag,
    input  logic [2*NCH-1:0]    cfg_inv_mode,
    input  logic                mem_we,
    input  logic [AW-1:0]       mem_waddr,
    input  logic [DW-1:0]       mem_wdata,
    output logic [15:0]         conflict_cnt
);

    localparam int NBANK = 1 << BANK_BITS;
    localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [NCH-1:0] grant;
    logic           stall_any;

    function automatic logic [DW-1:0] invert(input logic [DW-1:0] d, input logic [1:0] mode);
        logic [DW-1:0] r;
        r = d;
        case (mode)
            2'b01: for (int k = 0; k < DW/8; k++) r[8*k +: 8] = d[8*(DW/8-1-k) +: 8];
            2'b10: for (int k = 0; k < DW/8; k++)
                       for (int j = 0; j < 8; j++) r[8*k+j] = d[8*k+7-j];
            2'b11: for (int i = 0; i < DW; i++) r[i] = d[DW-1-i];
            default: r = d;
        endcase
        return r;
    endfunction

    // Backdoor write; reads of the same word in this cycle see the old value.
    always_ff @(posedge clk983m) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Walk channels in priority order, first claimant of a bank wins it.
    always_comb begin
        logic [NBANK-1:0]     bank_busy;
        logic [BANK_BITS-1:0] bank;
        int                   ch;
        grant     = '0;
        bank_busy = '0;
        bank      = '0;
        ch        = 0;
        for (int p = 0; p < NCH; p++) begin
            ch   = (ARB_MODE == 1) ? (int'(rr_ptr_q) + p) % NCH : p;
            bank = ch_raddr[ch*AW + AW-1 -: BANK_BITS];
            if (ch_re[ch] && !bank_busy[bank]) begin
                grant[ch]       = 1'b1;
                bank_busy[bank] = 1'b1;
            end
        end
    end

    assign ch_rdy    = clkgen_rst ? '0 : grant;
    assign stall_any = |(ch_re & ~grant);

    always_comb begin
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        if (stall_any) begin
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
            if (ARB_MODE == 1) begin
                rr_ptr_d = (rr_ptr_q == PW'(NCH-1)) ? '0 : rr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk983m) begin
        if (clkgen_rst) begin
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign conflict_cnt = cnt_q;

    // Stage 0 captures the inverted word at accept; the last stage drives the outputs.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [LAT-1:0] vld_q;
        logic [DW-1:0]  data_q [LAT];
        logic [TW-1:0]  tag_q  [LAT];
        logic           accept;

        assign accept = ch_re[gi] & ch_rdy[gi];

        always_ff @(posedge clk983m) begin
            if (clkgen_rst) begin
                vld_q <= '0;
                for (int k = 0; k < LAT; k++) begin
                    data_q[k] <= '0;
                    tag_q[k]  <= '0;
                end
            end else begin
                vld_q[0] <= accept;
                if (accept) begin
                    data_q[0] <= invert(mem_q[ch_raddr[gi*AW +: AW]], cfg_inv_mode[2*gi +: 2]);
                    tag_q[0]  <= ch_tag[gi*TW +: TW];
                end
                for (int k = 1; k < LAT; k++) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                        tag_q[k]  <= tag_q[k-1];
                    end
                end
            end
        end

        assign ch_rvld[gi]           = vld_q[LAT-1];
        assign ch_rdata[gi*DW +: DW] = data_q[LAT-1];
        assign ch_rtag[gi*TW +: TW]  = tag_q[LAT-1];
    end

endmodule

// File: tb/tb_l2_rd_mem_arb.sv
// Bench for l2_rd_mem_arb: one instance per arbitration mode, directed vectors,
// then randomized traffic against a queue-based reference model.
module tb_l2_rd_mem_arb;

    localparam int NCH = 2;
    localparam int AW  = 14;
    localparam int DW  = 128;
    localparam int TW  = 12;
    localparam int BB  = 4;
    localparam int LAT = 5;
    localparam int NRND = 3000;

    logic clk = 1'b0;
    logic srst;

    logic [NCH-1:0]    re    [2];
    logic [NCH-1:0]    rdy   [2];
    logic [NCH-1:0]    rvld  [2];
    logic [NCH*AW-1:0] raddr [2];
    logic [NCH*TW-1:0] tag   [2];
    logic [NCH*TW-1:0] rtag  [2];
    logic [NCH*DW-1:0] rdata [2];
    logic [2*NCH-1:0]  inv   [2];
    logic              we    [2];
    logic [AW-1:0]     waddr [2];
    logic [DW-1:0]     wdata [2];
    logic [15:0]       cnt   [2];

    int n_cmp;
    int n_bad;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        l2_rd_mem_arb #(
            .NCH(NCH), .AW(AW), .DW(DW), .TW(TW), .BANK_BITS(BB), .LAT(LAT), .ARB_MODE(gi)
        ) u_dut (
            .clk983m      (clk),
            .clkgen_rst   (srst),
            .ch_re        (re[gi]),
            .ch_raddr     (raddr[gi]),
            .ch_tag       (tag[gi]),
            .ch_rdy       (rdy[gi]),
            .ch_rvld      (rvld[gi]),
            .ch_rdata     (rdata[gi]),
            .ch_rtag      (rtag[gi]),
            .cfg_inv_mode (inv[gi]),
            .mem_we       (we[gi]),
            .mem_waddr    (waddr[gi]),
            .mem_wdata    (wdata[gi]),
            .conflict_cnt (cnt[gi])
        );
    end

    typedef struct {
        logic [1:0]    mode;
        logic [TW-1:0] tg;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } exp_t;

    exp_t          eq [2*NCH][$];
    logic [DW-1:0] mm   [2][16];
    int            pidx [2][NCH];
    int            widx [2];
    logic          hold [2][NCH];
    int            m_rr [2];
    int            m_cnt[2];
    int            cyc;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            re[k] = '0; raddr[k] = '0; tag[k] = '0; inv[k] = '0;
            we[k] = 1'b0; waddr[k] = '0; wdata[k] = '0;
        end
    endtask

    task automatic do_reset();
        idle();
        srst = 1'b1;
        nxt();
        nxt();
        srst = 1'b0;
    endtask

    task automatic req(input int k, input int ch, input logic en, input logic [AW-1:0] a,
                       input logic [TW-1:0] t, input logic [1:0] m);
        re[k][ch]               = en;
        raddr[k][ch*AW +: AW]   = a;
        tag[k][ch*TW +: TW]     = t;
        inv[k][2*ch +: 2]       = m;
    endtask

    task automatic bd_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[k] = 1'b1; waddr[k] = a; wdata[k] = d;
        nxt();
        we[k] = 1'b0;
    endtask

    function automatic logic [AW-1:0] pool(input int i);
        return AW'(((i % 4) << 10) | ((i / 4) * 3));
    endfunction

    // Reference transform written straight from the per-mode bit mapping rules.
    function automatic logic [DW-1:0] ref_inv(input logic [DW-1:0] d, input logic [1:0] m);
        logic [DW-1:0] r;
        r = d;
        for (int i = 0; i < DW; i++) begin
            case (m)
                2'b01: r[i] = d[8*(DW/8 - 1 - i/8) + i%8];
                2'b10: r[i] = d[8*(i/8) + 7 - i%8];
                2'b11: r[i] = d[DW-1-i];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    task automatic model_step(input int k);
        bit            used [16];
        logic [NCH-1:0] er;
        int            start, ch, b, qi;
        exp_t          e;
        er = '0;
        for (int i = 0; i < 16; i++) used[i] = 1'b0;
        start = (k == 1) ? m_rr[k] : 0;
        for (int p = 0; p < NCH; p++) begin
            ch = (start + p) % NCH;
            if (re[k][ch]) begin
                b = int'(raddr[k][ch*AW +: AW]) >> (AW - BB);
                if (!used[b]) begin
                    used[b] = 1'b1;
                    er[ch]  = 1'b1;
                end
            end
        end
        chk($sformatf("rnd%0d_cnt", k), cnt[k], m_cnt[k]);
        for (int c = 0; c < NCH; c++) begin
            qi = k*NCH + c;
            chk($sformatf("rnd%0d_rdy%0d", k, c), rdy[k][c], er[c]);
            if (eq[qi].size() > 0 && eq[qi][0].due == cyc) begin
                e = eq[qi].pop_front();
                chk($sformatf("rnd%0d_rvld%0d", k, c), rvld[k][c], 1'b1);
                chk($sformatf("rnd%0d_rdata%0d", k, c), rdata[k][c*DW +: DW], e.d);
                chk($sformatf("rnd%0d_rtag%0d", k, c), rtag[k][c*TW +: TW], e.t);
            end else begin
                chk($sformatf("rnd%0d_rvld%0d", k, c), rvld[k][c], 1'b0);
            end
        end
        if ((re[k] & ~er) != '0) begin
            if (m_cnt[k] < 65535) m_cnt[k]++;
            if (k == 1) m_rr[k] = (m_rr[k] + 1) % NCH;
        end
        for (int c = 0; c < NCH; c++) begin
            if (er[c]) begin
                e.due = cyc + LAT;
                e.d   = ref_inv(mm[k][pidx[k][c]], inv[k][2*c +: 2]);
                e.t   = tag[k][c*TW +: TW];
                eq[k*NCH + c].push_back(e);
            end
            hold[k][c] = re[k][c] & ~er[c];
        end
        if (we[k]) mm[k][widx[k]] = wdata[k];
    endtask

    localparam logic [DW-1:0] D10  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [DW-1:0] WA   = 128'hA0A0A0A0_11111111_22222222_33333333;
    localparam logic [DW-1:0] WB   = 128'hB0B0B0B0_44444444_55555555_66666666;
    localparam logic [DW-1:0] WC   = 128'hC0C0C0C0_77777777_88888888_99999999;
    localparam logic [DW-1:0] WOLD = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [DW-1:0] WNEW = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;

    initial begin
        vec_t vt [4];
        vt[0] = '{2'b00, 12'h05A, D10};
        vt[1] = '{2'b01, 12'h0A1, 128'hFFEEDDCC_BBAA9988_77665544_33221100};
        vt[2] = '{2'b10, 12'h0B2, 128'h008844CC_22AA66EE_119955DD_33BB77FF};
        vt[3] = '{2'b11, 12'h0C3, 128'hFF77BB33_DD559911_EE66AA22_CC448800};
        n_cmp = 0;
        n_bad = 0;

        // Reset state, with requests asserted to show ch_rdy is forced low.
        srst = 1'b1;
        idle();
        nxt();
        req(0, 0, 1'b1, 14'h0010, '0, 2'b00);
        req(1, 1, 1'b1, 14'h0010, '0, 2'b00);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_rdy", rdy[k], '0);
            chk("rst_rvld", rvld[k], '0);
            chk("rst_rdata", rdata[k][DW-1:0], '0);
            chk("rst_rtag", rtag[k], '0);
            chk("rst_cnt", cnt[k], '0);
        end
        nxt();
        idle();
        srst = 1'b0;

        // Inversion table on ch0 of the fixed-priority instance.
        bd_write(0, 14'h0010, D10);
        for (int i = 0; i < 4; i++) begin
            req(0, 0, 1'b1, 14'h0010, vt[i].tg, vt[i].mode);
            @(negedge clk);
            chk("inv_rdy", rdy[0][0], 1'b1);
            nxt();
            req(0, 0, 1'b0, 14'h0010, vt[i].tg, vt[i].mode);
            for (int c = 1; c <= LAT + 1; c++) begin
                @(negedge clk);
                chk($sformatf("inv%0d_rvld_c%0d", i, c), rvld[0][0], (c == LAT));
                if (c >= LAT) begin
                    chk($sformatf("inv%0d_rdata", i), rdata[0][DW-1:0], vt[i].exp);
                    chk($sformatf("inv%0d_rtag", i), rtag[0][TW-1:0], vt[i].tg);
                end
                nxt();
            end
        end

        // Same-bank conflict under fixed priority.
        do_reset();
        bd_write(0, 14'h0400, WA);
        bd_write(0, 14'h0401, WB);
        bd_write(0, 14'h0800, WC);
        req(0, 0, 1'b1, 14'h0400, 12'h001, 2'b00);
        req(0, 1, 1'b1, 14'h0401, 12'h002, 2'b00);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("cf_rdy0_c0", rdy[0][0], 1'b1);
                chk("cf_rdy1_c0", rdy[0][1], 1'b0);
            end
            if (c == 1) begin
                chk("cf_rdy0_c1", rdy[0][0], 1'b0);
                chk("cf_rdy1_c1", rdy[0][1], 1'b1);
            end
            chk($sformatf("cf_rvld0_c%0d", c), rvld[0][0], (c == LAT));
            chk($sformatf("cf_rvld1_c%0d", c), rvld[0][1], (c == LAT + 1));
            if (c == LAT) begin
                chk("cf_rdata0", rdata[0][DW-1:0], WA);
                chk("cf_rtag0", rtag[0][TW-1:0], 12'h001);
            end
            if (c == LAT + 1) begin
                chk("cf_rdata1", rdata[0][DW +: DW], WB);
                chk("cf_rtag1", rtag[0][TW +: TW], 12'h002);
            end
            nxt();
            if (c == 0) req(0, 0, 1'b0, 14'h0400, 12'h001, 2'b00);
            if (c == 1) req(0, 1, 1'b0, 14'h0401, 12'h002, 2'b00);
        end
        @(negedge clk);
        chk("cf_cnt", cnt[0], 16'd1);
        nxt();

        // Different banks are served in parallel.
        req(0, 0, 1'b1, 14'h0400, 12'h003, 2'b00);
        req(0, 1, 1'b1, 14'h0800, 12'h004, 2'b00);
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (c == 0) chk("par_rdy", rdy[0], 2'b11);
            chk($sformatf("par_rvld_c%0d", c), rvld[0], (c == LAT) ? 2'b11 : 2'b00);
            if (c == LAT) begin
                chk("par_rdata0", rdata[0][DW-1:0], WA);
                chk("par_rdata1", rdata[0][DW +: DW], WC);
                chk("par_rtag", rtag[0], {12'h004, 12'h003});
            end
            nxt();
            if (c == 0) idle();
        end
        @(negedge clk);
        chk("par_cnt", cnt[0], 16'd1);
        nxt();

        // Rotating priority, both channels hammering bank 3.
        do_reset();
        req(1, 0, 1'b1, 14'h0C00, 12'h010, 2'b00);
        req(1, 1, 1'b1, 14'h0C01, 12'h020, 2'b00);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("rr_rdy0_c%0d", c), rdy[1][0], (c % 2 == 0));
            chk($sformatf("rr_rdy1_c%0d", c), rdy[1][1], (c % 2 == 1));
            nxt();
        end
        idle();
        @(negedge clk);
        chk("rr_cnt", cnt[1], 16'd8);
        nxt();

        // Read-first when a backdoor write hits the word being read.
        do_reset();
        bd_write(0, 14'h0020, WOLD);
        req(0, 0, 1'b1, 14'h0020, 12'h007, 2'b00);
        we[0] = 1'b1; waddr[0] = 14'h0020; wdata[0] = WNEW;
        for (int c = 0; c <= LAT + 2; c++) begin
            @(negedge clk);
            if (c < 2) chk($sformatf("rf_rdy_c%0d", c), rdy[0][0], 1'b1);
            chk($sformatf("rf_rvld_c%0d", c), rvld[0][0], (c == LAT || c == LAT + 1));
            if (c == LAT) begin
                chk("rf_old", rdata[0][DW-1:0], WOLD);
                chk("rf_tag_old", rtag[0][TW-1:0], 12'h007);
            end
            if (c == LAT + 1) begin
                chk("rf_new", rdata[0][DW-1:0], WNEW);
                chk("rf_tag_new", rtag[0][TW-1:0], 12'h008);
            end
            nxt();
            if (c == 0) begin
                we[0] = 1'b0;
                req(0, 0, 1'b1, 14'h0020, 12'h008, 2'b00);
            end
            if (c == 1) idle();
        end

        // Reset two cycles after accept discards the in-flight read.
        req(0, 0, 1'b1, 14'h0010, 12'h009, 2'b00);
        @(negedge clk);
        chk("mr_rdy", rdy[0][0], 1'b1);
        nxt();
        idle();
        nxt();
        srst = 1'b1;
        nxt();
        srst = 1'b0;
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clk);
            chk($sformatf("mr_rvld_c%0d", c), rvld[0], '0);
            chk($sformatf("mr_rdata_c%0d", c), rdata[0][DW-1:0], '0);
            chk($sformatf("mr_rtag_c%0d", c), rtag[0], '0);
            chk($sformatf("mr_cnt_c%0d", c), cnt[0], '0);
            nxt();
        end

        // Randomized traffic on both instances against the reference model.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 2; k++) begin
                mm[k][i] = {$urandom, $urandom, $urandom, $urandom};
                we[k] = 1'b1; waddr[k] = pool(i); wdata[k] = mm[k][i];
            end
            nxt();
        end
        idle();
        for (int k = 0; k < 2; k++) begin
            m_rr[k] = 0; m_cnt[k] = 0; widx[k] = 0;
            for (int c = 0; c < NCH; c++) begin
                hold[k][c] = 1'b0;
                pidx[k][c] = 0;
                eq[k*NCH + c].delete();
            end
        end
        cyc = 0;
        for (int n = 0; n < NRND + LAT + 2; n++) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < NCH; c++) begin
                    if (n >= NRND) begin
                        re[k][c] = 1'b0;
                    end else if (!(hold[k][c] && $urandom_range(9) != 0)) begin
                        pidx[k][c] = $urandom_range(15);
                        req(k, c, ($urandom_range(99) < 60), pool(pidx[k][c]),
                            TW'($urandom), 2'($urandom_range(3)));
                    end
                end
                we[k] = (n < NRND) && ($urandom_range(4) == 0);
                widx[k]  = $urandom_range(15);
                waddr[k] = pool(widx[k]);
                wdata[k] = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            model_step(0);
            model_step(1);
            cyc++;
            nxt();
        end
        for (int q = 0; q < 2*NCH; q++) begin
            chk($sformatf("rnd_drain_q%0d", q), 128'(eq[q].size()), '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
